wb_initiator: RTL and testbench
===============================

Name: wb_initiator

Overview:
Wishbone classic single-transfer initiator (bus master) that drives the master side of the existing Wishbone address-decode mux. It converts a simple valid/ready command stream into one Wishbone read or write cycle at a time. Each transfer ends either on the responder's ack or on a configurable timeout. The result (read data, error flag) is returned on a valid/ready response port. Typical users are a test sequencer or a management bridge that needs to reach the waveform-generator peripherals.

Parameters:
TIMEOUT, 16, max cycles stb may stay asserted without ack before abort; 0 disables the timeout
CNT_WIDTH, 8, width of the saturating timeout-event counter

Ports:
io_wbs_clk  input  1  system clock; all logic on rising edge
io_wbs_rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  initiator can accept a command
cmd_we  input  1  1=write, 0=read
cmd_adr  input  32  byte address
cmd_wdata  input  32  write data (ignored for reads)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  read data (0 for writes and for timeouts)
rsp_err  output  1  1=transfer aborted by timeout
timeout_cnt  output  CNT_WIDTH  count of timeouts since reset, saturating
io_wbm_adr  output  32  Wishbone address
io_wbm_datwr  output  32  Wishbone write data
io_wbm_datrd  input  32  Wishbone read data
io_wbm_we  output  1  Wishbone write enable
io_wbm_stb  output  1  Wishbone strobe
io_wbm_ack  input  1  Wishbone acknowledge
io_wbm_cyc  output  1  Wishbone cycle

Behaviour:
- Single clock io_wbs_clk. Reset io_wbs_rst is synchronous and active-high.
- Reset values: state=IDLE; cmd_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; timeout_cnt=0; io_wbm_cyc=io_wbm_stb=io_wbm_we=0; io_wbm_adr=io_wbm_datwr=0.
- All outputs are registered except cmd_ready, which is the combinational decode (state==IDLE).
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch adr/wdata/we into io_wbm_* and set cyc=stb=1 on the same edge; next state BUS.
  - The wait counter is cleared to 0.
  - io_wbm_adr, io_wbm_datwr and io_wbm_we hold their last values when idle; only cyc and stb indicate activity.
- BUS:
  - cyc=stb=1; adr/datwr/we stable for the whole cycle.
  - io_wbm_ack sampled high: clear cyc/stb on that edge. Set rsp_rdata = we ? 0 : io_wbm_datrd, rsp_err=0, rsp_valid=1; next state RESP.
  - No ack: the wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack, that edge clears cyc/stb and sets rsp_rdata=0, rsp_err=1, rsp_valid=1. timeout_cnt increments, saturating at all-ones. Next state RESP.
  - stb is therefore high for at most TIMEOUT cycles.
  - Ack in the same cycle as timeout expiry: ack wins; treat as success, no timeout counted.
  - Minimum latency: command accepted at edge N, cyc/stb high from N; ack at edge N+1 gives rsp_valid high from N+1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid&rsp_ready.
  - On that handshake, rsp_valid=0 and next state IDLE. A new command can be accepted at the following edge at the earliest.
- cmd_ready=0 in BUS and RESP. cmd_valid is ignored outside IDLE, and no command is buffered.
- io_wbm_ack outside BUS (late or spurious ack) is ignored and has no side effects.
- Reset asserted mid-transfer: the next edge forces all reset values. cyc/stb drop and any pending response is discarded.
- Wait counter width is $clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
- Write with immediate ack: cmd_we=1, adr=0x30000004, wdata=0xA5A5_1234; responder acks the 1st BUS cycle -> cyc/stb high exactly 1 cycle with matching adr/datwr/we=1; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: adr=0x30001008; ack on the 4th stb cycle with datrd=0xCAFEF00D -> stb high 4 cycles; rsp_rdata=0xCAFEF00D, rsp_err=0.
- Timeout: TIMEOUT=16, responder never acks -> stb high exactly 16 cycles then low; rsp_err=1, rsp_rdata=0, timeout_cnt=1. Repeat 300 times with CNT_WIDTH=8 -> timeout_cnt saturates at 255.
- Ack on the final timeout cycle (16th) -> success response, rsp_err=0, timeout_cnt unchanged.
- Backpressure: hold rsp_ready=0 for 10 cycles while cmd_valid stays high with a second command -> cmd_ready=0 and rsp_* stable throughout; the second command is accepted only after the response handshake.
- Reset mid-read: assert io_wbs_rst during BUS -> next edge cyc=stb=0, rsp_valid=0, cmd_ready=1; a later ack pulse is ignored.

Source files
------------

// File: rtl/wb_initiator_if.sv
// Command/response stream plus Wishbone master signals for wb_initiator.
// The master modport is the initiator's own view of the bundle.
interface wb_initiator_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [31:0]          cmd_adr;
  logic [31:0]          cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [CNT_WIDTH-1:0] timeout_cnt;
  logic [31:0]          io_wbm_adr;
  logic [31:0]          io_wbm_datwr;
  logic [31:0]          io_wbm_datrd;
  logic                 io_wbm_we;
  logic                 io_wbm_stb;
  logic                 io_wbm_ack;
  logic                 io_wbm_cyc;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_wdata, rsp_ready, io_wbm_datrd, io_wbm_ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, timeout_cnt,
           io_wbm_adr, io_wbm_datwr, io_wbm_we, io_wbm_stb, io_wbm_cyc
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_wdata, rsp_ready, io_wbm_datrd, io_wbm_ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, timeout_cnt,
           io_wbm_adr, io_wbm_datwr, io_wbm_we, io_wbm_stb, io_wbm_cyc
  );
endinterface

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one command -> one bus cycle
// -> one response, with an optional stb-without-ack timeout.
module wb_initiator #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic              io_wbs_clk,
  input  logic              io_wbs_rst,
  wb_initiator_if.master    bus
);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          expired;

  assign bus.cmd_ready = (state == IDLE);
  // Counter reaches LAST on the TIMEOUT-th stb cycle, bounding stb to TIMEOUT cycles.
  assign expired = (TIMEOUT != 0) && (wait_cnt == LAST);

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_err      <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.timeout_cnt  <= '0;
      bus.io_wbm_cyc   <= 1'b0;
      bus.io_wbm_stb   <= 1'b0;
      bus.io_wbm_we    <= 1'b0;
      bus.io_wbm_adr   <= '0;
      bus.io_wbm_datwr <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (bus.cmd_valid) begin
            bus.io_wbm_adr   <= bus.cmd_adr;
            bus.io_wbm_datwr <= bus.cmd_wdata;
            bus.io_wbm_we    <= bus.cmd_we;
            bus.io_wbm_cyc   <= 1'b1;
            bus.io_wbm_stb   <= 1'b1;
            state            <= BUS;
          end
        end
        BUS: begin
          if (bus.io_wbm_ack) begin
            // Ack beats a simultaneous timeout expiry.
            bus.io_wbm_cyc <= 1'b0;
            bus.io_wbm_stb <= 1'b0;
            bus.rsp_rdata  <= bus.io_wbm_we ? 32'h0 : bus.io_wbm_datrd;
            bus.rsp_err    <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else if (expired) begin
            bus.io_wbm_cyc <= 1'b0;
            bus.io_wbm_stb <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b1;
            bus.rsp_valid  <= 1'b1;
            if (bus.timeout_cnt != '1)
              bus.timeout_cnt <= bus.timeout_cnt + 1'b1;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: write/read, wait states, timeout and its
// saturation, ack-at-expiry, response backpressure, reset mid-transfer.
module tb_wb_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wb_initiator_if #(.CNT_WIDTH(8)) bus ();

  wb_initiator #(.TIMEOUT(16), .CNT_WIDTH(8)) dut (
    .io_wbs_clk (clk),
    .io_wbs_rst (rst),
    .bus        (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge; it must be accepted from IDLE.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_wdata = wd;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Responder: acks on stb cycle ack_at (0 = never); reports stb length and bus stability.
  task automatic run_bus(input int ack_at, input logic [31:0] rd, input logic we,
                         input logic [31:0] adr, input logic [31:0] wd,
                         output int cycles, output logic stable);
    cycles = 0;
    stable = 1'b1;
    while (bus.io_wbm_stb && cycles < 100) begin
      cycles++;
      if (!bus.io_wbm_cyc || bus.io_wbm_we !== we || bus.io_wbm_adr !== adr ||
          bus.io_wbm_datwr !== wd)
        stable = 1'b0;
      bus.io_wbm_ack   = (cycles == ack_at);
      bus.io_wbm_datrd = rd;
      step();
    end
    bus.io_wbm_ack = 1'b0;
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int   n;
    logic ok;
    logic [31:0] hold_rd;
    logic        hold_err;

    bus.cmd_valid    = 1'b0;
    bus.cmd_we       = 1'b0;
    bus.cmd_adr      = '0;
    bus.cmd_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    bus.io_wbm_datrd = '0;
    bus.io_wbm_ack   = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_cyc_stb", {30'b0, bus.io_wbm_cyc, bus.io_wbm_stb}, 32'd0);
    chk("rst_adr", bus.io_wbm_adr, 32'h0);
    chk("rst_tcnt", {24'b0, bus.timeout_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // Write, immediate ack
    issue(1'b1, 32'h3000_0004, 32'hA5A5_1234);
    chk("wr_cmd_ready_busy", {31'b0, bus.cmd_ready}, 32'd0);
    run_bus(1, 32'hDEAD_BEEF, 1'b1, 32'h3000_0004, 32'hA5A5_1234, n, ok);
    chk("wr_stb_len", n, 32'd1);
    chk("wr_bus_stable", {31'b0, ok}, 32'd1);
    chk("wr_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("wr_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
    take_rsp();
    chk("wr_done_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("wr_done_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("idle_adr_hold", bus.io_wbm_adr, 32'h3000_0004);

    // Read, three wait states
    issue(1'b0, 32'h3000_1008, 32'h0);
    run_bus(4, 32'hCAFE_F00D, 1'b0, 32'h3000_1008, 32'h0, n, ok);
    chk("rd_stb_len", n, 32'd4);
    chk("rd_bus_stable", {31'b0, ok}, 32'd1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    chk("rd_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    take_rsp();

    // Timeout, never acked
    issue(1'b0, 32'h3000_2000, 32'h0);
    run_bus(0, 32'h1111_1111, 1'b0, 32'h3000_2000, 32'h0, n, ok);
    chk("to_stb_len", n, 32'd16);
    chk("to_rsp_err", {31'b0, bus.rsp_err}, 32'd1);
    chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("to_tcnt", {24'b0, bus.timeout_cnt}, 32'd1);
    take_rsp();

    // Ack on the final allowed cycle
    issue(1'b0, 32'h3000_3000, 32'h0);
    run_bus(16, 32'h1234_5678, 1'b0, 32'h3000_3000, 32'h0, n, ok);
    chk("edge_stb_len", n, 32'd16);
    chk("edge_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("edge_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("edge_tcnt", {24'b0, bus.timeout_cnt}, 32'd1);
    take_rsp();

    // Backpressure with a second command waiting
    issue(1'b0, 32'h3000_4000, 32'h0);
    run_bus(2, 32'h0BAD_F00D, 1'b0, 32'h3000_4000, 32'h0, n, ok);
    hold_rd  = bus.rsp_rdata;
    hold_err = bus.rsp_err;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_adr   = 32'h3000_5000;
    bus.cmd_wdata = 32'h5555_AAAA;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_ready || !bus.rsp_valid || bus.io_wbm_cyc ||
          bus.rsp_rdata !== hold_rd || bus.rsp_err !== hold_err)
        ok = 1'b0;
      step();
    end
    chk("bp_stable", {31'b0, ok}, 32'd1);
    chk("bp_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_hs_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("bp_not_yet", {31'b0, bus.io_wbm_cyc}, 32'd0);
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_second_cyc", {31'b0, bus.io_wbm_cyc}, 32'd1);
    chk("bp_second_adr", bus.io_wbm_adr, 32'h3000_5000);
    run_bus(1, 32'h0, 1'b1, 32'h3000_5000, 32'h5555_AAAA, n, ok);
    chk("bp_second_ok", {31'b0, ok}, 32'd1);
    take_rsp();

    // 299 more timeouts: 300 total saturates the counter at 255
    for (int i = 0; i < 299; i++) begin
      issue(1'b0, 32'h3000_6000, 32'h0);
      run_bus(0, 32'h0, 1'b0, 32'h3000_6000, 32'h0, n, ok);
      take_rsp();
    end
    chk("sat_tcnt", {24'b0, bus.timeout_cnt}, 32'd255);
    chk("sat_stb_len", n, 32'd16);

    // Reset in the middle of a read
    issue(1'b0, 32'h3000_7000, 32'h0);
    step();
    chk("mid_cyc", {31'b0, bus.io_wbm_cyc}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_cyc_stb", {30'b0, bus.io_wbm_cyc, bus.io_wbm_stb}, 32'd0);
    chk("mrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("mrst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("mrst_tcnt", {24'b0, bus.timeout_cnt}, 32'd0);
    bus.io_wbm_ack   = 1'b1;
    bus.io_wbm_datrd = 32'h7777_7777;
    step();
    bus.io_wbm_ack = 1'b0;
    step();
    chk("late_ack_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("late_ack_rdata", bus.rsp_rdata, 32'h0);
    chk("late_ack_ready", {31'b0, bus.cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
